// File: rtl/restador_display_mux_pkg.sv
// Shared types and constants for the restador_display_mux subtractor/readout.
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/restador_display_mux_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, WIDTH iterations.
module bin2bcd_seq
  import restador_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [WIDTH-1:0]               bin,
  output logic [bcd_width(DIGITS)-1:0]   bcd,
  output logic                           finished
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [CNT_W-1:0]       cnt;
  logic [BCD_W+WIDTH-1:0] work;
  logic [BCD_W+WIDTH-1:0] shifted;

  // One double-dabble step: correct every nibble >= 5, then shift the whole word left
  always_comb begin
    work = {bcd_q, bin_q};
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH+4*i +: 4] >= 4'd5)
        work[WIDTH+4*i +: 4] = work[WIDTH+4*i +: 4] + 4'd3;
    end
    shifted = work << 1;
  end

  // Load the operand, then iterate until the remaining-step counter reaches zero
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt   <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      {bcd_q, bin_q} <= shifted;
      cnt            <= cnt - 1'b1;
    end
  end

  assign bcd      = bcd_q;
  assign finished = (cnt == '0);

endmodule

// File: rtl/restador_display_mux.sv
// Sequential unsigned subtractor with BCD conversion and a multiplexed
// common-anode 7-segment readout (sign position plus DIGITS digits).
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero digit (the least significant digit always shows).
module restador_display_mux
  import restador_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              busy,
  output logic              done,
  output logic              borrow,
  output logic [WIDTH-1:0]  magnitude,
  output logic [6:0]        seg,
  output logic [DIGITS:0]   an
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

  state_t             state;
  logic [WIDTH:0]     diff_ab;
  logic               a_lt_b;
  logic [WIDTH-1:0]   mag_next;
  logic               load;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_finished;
  logic [BCD_W-1:0]   disp_bcd;
  logic               disp_sign;
  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [DIGITS-1:0]  lz_blank;
  logic [3:0]         cur_nib;
  logic               cur_blank;

  // The extra top bit of the widened difference is the borrow
  assign diff_ab  = {1'b0, A} - {1'b0, B};
  assign a_lt_b   = diff_ab[WIDTH];
  assign mag_next = a_lt_b ? (B - A) : diff_ab[WIDTH-1:0];
  assign load     = (state == IDLE) && start;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bin      (mag_next),
    .bcd      (conv_bcd),
    .finished (conv_finished)
  );

  // Control FSM: capture operands, wait for conversion, publish result to display
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      borrow    <= 1'b0;
      magnitude <= '0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            borrow    <= a_lt_b;
            magnitude <= mag_next;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          if (conv_finished) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            disp_bcd  <= conv_bcd;
            disp_sign <= borrow;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scan: each position stays lit for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == LAST_CNT) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    lz_blank = '0;
    seen_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      lz_blank[i] = !seen_nz;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Pick the nibble and blanking flag for the currently scanned digit
  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_nib   = disp_bcd[4*i +: 4];
        cur_blank = lz_blank[i];
      end
    end
  end

  // Drive one anode low and its segment pattern; everything dark during reset
  always_comb begin
    seg = SEG_BLANK;
    an  = '1;
    if (!rst) begin
      an[digit_idx] = 1'b0;
      if (digit_idx == LAST_IDX) seg = disp_sign ? SEG_MINUS : SEG_BLANK;
      else if (!cur_blank)       seg = seg_digit(cur_nib);
    end
  end

endmodule

// File: tb/tb_restador_display_mux.sv
// Directed bench for restador_display_mux (WIDTH=8, DIGITS=3, SCAN_DIV=4).
module tb_restador_display_mux;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] SG_0  = 7'b1000000;
  localparam logic [6:0] SG_1  = 7'b1111001;
  localparam logic [6:0] SG_2  = 7'b0100100;
  localparam logic [6:0] SG_5  = 7'b0010010;
  localparam logic [6:0] SG_7  = 7'b1111000;
  localparam logic [6:0] SG_BL = 7'b1111111;
  localparam logic [6:0] SG_MI = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SG_BL;
`else
  localparam logic [6:0] LZ = SG_0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             borrow;
  logic [WIDTH-1:0] magnitude;
  logic [6:0]       seg;
  logic [DIGITS:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  restador_display_mux #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .borrow    (borrow),
    .magnitude (magnitude),
    .seg       (seg),
    .an        (an)
  );

  // Pulse start for one edge and count edges until done is seen (-1 if never)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    lat = -1;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Record the segment pattern shown at each anode over one full scan
  task automatic read_display(output logic [27:0] segs);
    segs = '0;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk); #1;
      case (an)
        4'b1110: segs[6:0]   = seg;
        4'b1101: segs[13:7]  = seg;
        4'b1011: segs[20:14] = seg;
        4'b0111: segs[27:21] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
    n_tests++; if (magnitude !== 8'd0) begin n_fail++; $display("FAIL reset_magnitude: got %0d expected 0", magnitude); end
    n_tests++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
    n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8 * SCAN_DIV; k++) begin
      exp_an = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      n_tests++;
      if (an !== exp_an) begin
        n_fail++;
        $display("FAIL scan_an[%0d]: got %b expected %b", k, an, exp_an);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_subtract(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic eb, input logic [7:0] em, input logic [27:0] ed);
    int lat;
    logic [27:0] segs;
    run_op(a, b, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL %s latency: got %0d expected 9", name, lat); end
    n_tests++; if (borrow !== eb) begin n_fail++; $display("FAIL %s borrow: got %b expected %b", name, borrow, eb); end
    n_tests++; if (magnitude !== em) begin n_fail++; $display("FAIL %s magnitude: got %0d expected %0d", name, magnitude, em); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %b expected 0", name, done); end
    read_display(segs);
    n_tests++; if (segs !== ed) begin n_fail++; $display("FAIL %s display: got %h expected %h", name, segs, ed); end
  endtask

  task automatic test_start_ignored();
    int dones;
    int first_done;
    dones = 0;
    first_done = -1;
    @(negedge clk);
    A = 8'd20; B = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_conv: got %b expected 1", busy); end
    for (int n = 1; n <= 24; n++) begin
      start = (n == 3);
      if (n == 3) begin A = 8'd1; B = 8'd200; end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = n;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL ignored_start_done_count: got %0d expected 1", dones); end
    n_tests++; if (first_done !== 9) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected 9", first_done); end
    n_tests++; if (magnitude !== 8'd15) begin n_fail++; $display("FAIL ignored_start_magnitude: got %0d expected 15", magnitude); end
    n_tests++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL ignored_start_borrow: got %b expected 0", borrow); end
  endtask

  task automatic test_reset_mid_conv();
    int dones;
    logic [27:0] segs;
    dones = 0;
    @(negedge clk);
    A = 8'd9; B = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_tests++; if (magnitude !== 8'd0) begin n_fail++; $display("FAIL midrst_magnitude: got %0d expected 0", magnitude); end
    n_tests++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL midrst_seg: got %b expected 1111111", seg); end
    n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an: got %b expected 1111", an); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
    read_display(segs);
    n_tests++;
    if (segs !== {SG_BL, LZ, LZ, SG_0}) begin
      n_fail++;
      $display("FAIL midrst_display: got %h expected %h", segs, {SG_BL, LZ, LZ, SG_0});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    test_reset();
    test_scan();
    test_subtract("sub_6_4",     8'd6,   8'd4,   1'b0, 8'd2,   {SG_BL, LZ,   LZ,   SG_2});
    test_subtract("sub_3_4",     8'd3,   8'd4,   1'b1, 8'd1,   {SG_MI, LZ,   LZ,   SG_1});
    test_subtract("sub_5_5",     8'd5,   8'd5,   1'b0, 8'd0,   {SG_BL, LZ,   LZ,   SG_0});
    test_subtract("sub_0_255",   8'd0,   8'd255, 1'b1, 8'd255, {SG_MI, SG_2, SG_5, SG_5});
    test_subtract("sub_255_0",   8'd255, 8'd0,   1'b0, 8'd255, {SG_BL, SG_2, SG_5, SG_5});
    test_subtract("sub_200_93",  8'd200, 8'd93,  1'b0, 8'd107, {SG_BL, SG_1, SG_0, SG_7});
    test_start_ignored();
    test_reset_mid_conv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
